// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, PC tag queue, instruction buffer,
// redirect flush with drain of stale responses. Optional macro FETCH_BYPASS_EN enables the empty-buffer bypass.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_redirect_vld,
   input  logic [XLEN-1:0]               i_redirect_pc,
   output logic                          o_imem_req_vld,
   input  logic                          i_imem_req_rdy,
   output logic [XLEN-1:0]               o_imem_addr,
   input  logic                          i_imem_rsp_vld,
   input  logic [31:0]                   i_imem_rsp_data,
   output logic                          o_insn_vld,
   output logic [31:0]                   o_insn,
   output logic [XLEN-1:0]               o_insn_pc,
   input  logic                          i_insn_rdy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t          r_state, w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [CW-1:0]   r_outst, r_drop, r_cnt;
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr, r_tag_wr, r_tag_rd;
   logic [31:0]     r_buf_insn [FIFO_DEPTH];
   logic [XLEN-1:0] r_buf_pc   [FIFO_DEPTH];
   logic [XLEN-1:0] r_tag      [FIFO_DEPTH];

   logic            w_req_vld, w_req_fire;
   logic            w_rsp_inflight, w_rsp_acc, w_rsp_drop;
   logic            w_bypass, w_push, w_pop, w_buf_nonempty;
   logic [CW:0]     w_credit;
   logic [CW-1:0]   w_drop_load;
   logic [XLEN-1:0] w_tag_pc;
   logic            w_unused_pc_lsb;

   assign w_unused_pc_lsb = &{1'b0, i_redirect_pc[1:0]};
   assign w_credit        = {1'b0, r_cnt} + {1'b0, r_outst};
   assign w_req_vld       = (r_state == FETCH) && !i_redirect_vld && (w_credit < DEPTH_C);
   assign w_req_fire      = w_req_vld && i_imem_req_rdy;

   // Responses only count when something is actually in flight; stray pulses are ignored.
   assign w_rsp_inflight  = i_imem_rsp_vld && (r_outst != '0);
   assign w_rsp_acc       = (r_state == FETCH) && w_rsp_inflight && !i_redirect_vld;
   assign w_rsp_drop      = (r_state == DRAIN) && i_imem_rsp_vld && (r_drop != '0);
   assign w_drop_load     = (r_state == DRAIN) ? (r_drop - CW'(w_rsp_drop))
                                               : (r_outst - CW'(w_rsp_inflight));
   assign w_tag_pc        = r_tag[r_tag_rd];
   assign w_buf_nonempty  = (r_cnt != '0);

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_rsp_acc && !w_buf_nonempty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_pop  = w_buf_nonempty && i_insn_rdy;
   assign w_push = w_rsp_acc && !(w_bypass && i_insn_rdy);

   assign o_imem_req_vld = w_req_vld;
   assign o_imem_addr    = r_pc;
   assign o_insn_vld     = w_buf_nonempty || w_bypass;
   assign o_insn         = w_buf_nonempty ? r_buf_insn[r_rd_ptr] : (w_bypass ? i_imem_rsp_data : 32'h0);
   assign o_insn_pc      = w_buf_nonempty ? r_buf_pc[r_rd_ptr]   : (w_bypass ? w_tag_pc : '0);
   assign o_fifo_cnt     = r_cnt;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    w_state_next = FETCH;
         FETCH:   if (i_redirect_vld && (w_drop_load != '0)) w_state_next = DRAIN;
         DRAIN:   if (!i_redirect_vld && (r_drop == '0)) w_state_next = FETCH;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state  <= IDLE;
         r_pc     <= RESET_PC;
         r_outst  <= '0;
         r_drop   <= '0;
         r_cnt    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_tag_wr <= '0;
         r_tag_rd <= '0;
      end else begin
         r_state <= w_state_next;

         if (i_redirect_vld)
            r_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
         else if (w_req_fire)
            r_pc <= r_pc + XLEN'(4);

         if (w_req_fire)
            r_tag_wr <= r_tag_wr + AW'(1);

         // A redirect hands every in-flight request over to the drop counter.
         if (i_redirect_vld) begin
            r_outst  <= '0;
            r_drop   <= w_drop_load;
            r_cnt    <= '0;
            r_rd_ptr <= r_wr_ptr;
            r_tag_rd <= r_tag_wr;
         end else begin
            r_outst <= r_outst + CW'(w_req_fire) - CW'(w_rsp_acc);
            r_drop  <= r_drop - CW'(w_rsp_drop);
            r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_rsp_acc)
               r_tag_rd <= r_tag_rd + AW'(1);
         end

         if (w_push && !i_redirect_vld)
            r_wr_ptr <= r_wr_ptr + AW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_buf_insn[r_wr_ptr] <= i_imem_rsp_data;
         r_buf_pc[r_wr_ptr]   <= w_tag_pc;
      end
      if (w_req_fire)
         r_tag[r_tag_wr] <= r_pc;
   end

endmodule
